// File: rtl/control_fsm_pkg.sv
// Shared types for the multicycle RISC-V control path: opcodes, FSM states
// and the select encodings driven onto the datapath muxes.
package control_fsm_pkg;

  localparam logic [6:0] RType       = 7'b0110011;
  localparam logic [6:0] IType_logic = 7'b0010011;
  localparam logic [6:0] IType_load  = 7'b0000011;
  localparam logic [6:0] SType       = 7'b0100011;
  localparam logic [6:0] BType       = 7'b1100011;
  localparam logic [6:0] JType       = 7'b1101111;
  localparam logic [6:0] UType       = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    LUI      = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
  localparam logic [1:0] RESULT_DATA      = 2'b01;
  localparam logic [1:0] RESULT_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/control_fsm.sv
// Moore control FSM for the multicycle RISC-V core. Only FETCH looks at
// mem_ready for its write strobes; reset masks every architectural write.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_instr
);

  state_t state_q;
  state_t state_d;

  logic branch;
  logic pc_update;
  logic pc_gate;
  logic ir_write;
  logic mem_write;
  logic reg_write;
  logic illegal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = FETCH;
    branch    = 1'b0;
    pc_update = 1'b0;
    pc_gate   = 1'b1;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = ADR_PC;
    ResultSrc = RESULT_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;

    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RESULT_ALURESULT;
        pc_update = 1'b1;
        pc_gate   = mem_ready;
        ir_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          IType_load, SType: state_d = MEMADR;
          RType:             state_d = EXECUTER;
          IType_logic:       state_d = EXECUTEI;
          JType:             state_d = JAL;
          BType:             state_d = BEQ;
          UType:             state_d = LUI;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (opcode == IType_load)  state_d = MEMREAD;
        else if (opcode == SType)  state_d = MEMWRITE;
        else                       state_d = FETCH;
      end
      MEMREAD: begin
        AdrSrc  = ADR_ALUOUT;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = RESULT_DATA;
        reg_write = 1'b1;
      end
      // The store strobe is held through the whole stall so memory sees a stable request.
      MEMWRITE: begin
        AdrSrc    = ADR_ALUOUT;
        mem_write = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: reg_write = 1'b1;
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        state_d = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  assign PCWrite       = ~reset & ((branch & zero) | (pc_update & pc_gate));
  assign IRWrite       = ~reset & ir_write;
  assign MemWrite      = ~reset & mem_write;
  assign RegWrite      = ~reset & reg_write;
  assign illegal_instr = ~reset & illegal;
  assign state         = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class through the
// FSM and checks state and control strobes against hand-derived values.
module tb_control_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advances one rising edge; inputs are then driven at the falling edge.
  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [4:0] expected);
    check({tag, ".writes"}, {3'b000, PCWrite}, {3'b000, expected[4]});
    check({tag, ".irw"},    {3'b000, IRWrite}, {3'b000, expected[3]});
    check({tag, ".memw"},   {3'b000, MemWrite}, {3'b000, expected[2]});
    check({tag, ".regw"},   {3'b000, RegWrite}, {3'b000, expected[1]});
    check({tag, ".ill"},    {3'b000, illegal_instr}, {3'b000, expected[0]});
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    next_cycle; next_cycle; #1;
    check("rst.state", state, 4'd0);
    check_writes("rst", 5'b00000);
    check("rst.srcb", {2'b00, ALUSrcB}, 4'd2);
    check("rst.result", {2'b00, ResultSrc}, 4'd2);

    // add x3,x1,x2
    next_cycle; reset = 1'b0; opcode = 7'b0110011; #1;
    check("add.f.state", state, 4'd0);
    check_writes("add.f", 5'b11000);
    next_cycle; #1;
    check("add.d.state", state, 4'd1);
    check("add.d.srca", {2'b00, ALUSrcA}, 4'd1);
    check("add.d.srcb", {2'b00, ALUSrcB}, 4'd1);
    check_writes("add.d", 5'b00000);
    next_cycle; #1;
    check("add.ex.state", state, 4'd6);
    check("add.ex.aluop", {2'b00, ALUOp}, 4'd2);
    check("add.ex.srca", {2'b00, ALUSrcA}, 4'd2);
    check_writes("add.ex", 5'b00000);
    next_cycle; #1;
    check("add.wb.state", state, 4'd7);
    check("add.wb.result", {2'b00, ResultSrc}, 4'd0);
    check_writes("add.wb", 5'b00010);
    next_cycle; #1;
    check("add.end.state", state, 4'd0);

    // fetch stall: no strobes, stays in FETCH
    mem_ready = 1'b0; #1;
    check_writes("fstall", 5'b00000);
    next_cycle; #1;
    check("fstall.state", state, 4'd0);

    // lw x3,0(x1) with three stall cycles in MEMREAD
    mem_ready = 1'b1; opcode = 7'b0000011; #1;
    next_cycle; #1;
    check("lw.d.state", state, 4'd1);
    next_cycle; #1;
    check("lw.adr.state", state, 4'd2);
    check("lw.adr.srca", {2'b00, ALUSrcA}, 4'd2);
    check("lw.adr.srcb", {2'b00, ALUSrcB}, 4'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle; #1;
      check("lw.rd.state", state, 4'd3);
      check("lw.rd.adrsrc", {3'b000, AdrSrc}, 4'd1);
      check_writes("lw.rd", 5'b00000);
    end
    next_cycle; mem_ready = 1'b1; #1;
    check("lw.rd4.state", state, 4'd3);
    next_cycle; #1;
    check("lw.wb.state", state, 4'd4);
    check("lw.wb.result", {2'b00, ResultSrc}, 4'd1);
    check_writes("lw.wb", 5'b00010);
    next_cycle; #1;
    check("lw.end.state", state, 4'd0);

    // beq taken then not taken
    opcode = 7'b1100011; zero = 1'b1;
    next_cycle; next_cycle; #1;
    check("beq1.state", state, 4'd10);
    check("beq1.aluop", {2'b00, ALUOp}, 4'd1);
    check_writes("beq1", 5'b10000);
    next_cycle; #1;
    check("beq1.end.state", state, 4'd0);
    zero = 1'b0;
    next_cycle; next_cycle; #1;
    check("beq0.state", state, 4'd10);
    check_writes("beq0", 5'b00000);
    next_cycle; #1;
    check("beq0.end.state", state, 4'd0);

    // illegal opcode
    opcode = 7'h7F;
    next_cycle; #1;
    check("ill.state", state, 4'd1);
    check_writes("ill", 5'b00001);
    next_cycle; #1;
    check("ill.next.state", state, 4'd0);
    check("ill.next.flag", {3'b000, illegal_instr}, 4'd0);

    // jal
    opcode = 7'b1101111;
    next_cycle; next_cycle; #1;
    check("jal.state", state, 4'd9);
    check("jal.srca", {2'b00, ALUSrcA}, 4'd1);
    check("jal.srcb", {2'b00, ALUSrcB}, 4'd2);
    check_writes("jal", 5'b10000);
    next_cycle; #1;
    check("jal.wb.state", state, 4'd7);
    next_cycle; #1;
    check("jal.end.state", state, 4'd0);

    // lui
    opcode = 7'b0110111;
    next_cycle; next_cycle; #1;
    check("lui.state", state, 4'd11);
    check("lui.srca", {2'b00, ALUSrcA}, 4'd3);
    check("lui.srcb", {2'b00, ALUSrcB}, 4'd1);
    next_cycle; #1;
    check("lui.wb.state", state, 4'd7);
    next_cycle; #1;

    // addi
    opcode = 7'b0010011;
    next_cycle; next_cycle; #1;
    check("addi.state", state, 4'd8);
    check("addi.aluop", {2'b00, ALUOp}, 4'd2);
    check("addi.srcb", {2'b00, ALUSrcB}, 4'd1);
    next_cycle; #1;
    check("addi.wb.state", state, 4'd7);
    next_cycle; #1;

    // sw, stalled, then reset during MEMWRITE
    opcode = 7'b0100011;
    next_cycle; next_cycle; next_cycle; #1;
    check("sw.state", state, 4'd5);
    check("sw.adrsrc", {3'b000, AdrSrc}, 4'd1);
    mem_ready = 1'b0; #1;
    check_writes("sw", 5'b00100);
    next_cycle; #1;
    check("sw.stall.state", state, 4'd5);
    check_writes("sw.stall", 5'b00100);
    reset = 1'b1; #1;
    check_writes("sw.rst", 5'b00000);
    check("sw.rst.state", state, 4'd5);
    next_cycle; reset = 1'b0; mem_ready = 1'b1; #1;
    check("sw.after.state", state, 4'd0);
    check_writes("sw.after", 5'b11000);
    next_cycle; #1;
    check("sw.refetch.state", state, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Ports, in order: clk  in  1  core clock; reset  in  1  sync active-high reset.
REQ-003 Ports: opcode  in  7  instr[6:0] from instruction register; zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete.
REQ-004 Ports: PCWrite  out  1; AdrSrc  out  1 (0=PC, 1=ALUOut); MemWrite  out  1; IRWrite  out  1; RegWrite  out  1.
REQ-005 Ports: ResultSrc  out  2 (00=ALUOut, 01=Data, 10=ALUResult); ALUSrcA  out  2 (00=PC, 01=OldPC, 10=rs1, 11=zero); ALUSrcB  out  2 (00=rs2, 01=ImmExt, 10=const 4).
REQ-006 Ports: ALUOp  out  2 (00=add, 01=sub/compare, 10=funct-decoded); state  out  4 current state; illegal_instr  out  1.

Function
REQ-007 SHALL be a Moore FSM; outputs SHALL be decoded from the state register only, except the gating in REQ-008 and REQ-009.
REQ-008 Internal Branch and PCUpdate SHALL combine as PCWrite = (Branch & zero) | (PCUpdate & gate), where gate = mem_ready in FETCH and 1 in every other state.
REQ-009 IRWrite SHALL equal mem_ready in FETCH and SHALL be 0 in every other state.
REQ-010 States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, LUI=11.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1; stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes branch target).
REQ-013 DECODE next state by opcode: load/store -> MEMADR; RType -> EXECUTER; IType_logic -> EXECUTEI; JType -> JAL; BType -> BEQ; UType -> LUI.
REQ-014 DECODE with any other opcode: next state FETCH; illegal_instr=1 for that DECODE cycle only; no register, memory or PC write.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; goes to MEMREAD for IType_load and to MEMWRITE for SType.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00; holds while mem_ready=0; goes to MEMWB when mem_ready=1.
REQ-017 MEMWB: ResultSrc=01, RegWrite=1; goes to FETCH.
REQ-018 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; MemWrite SHALL stay high for every stall cycle; goes to FETCH when mem_ready=1.
REQ-019 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1; goes to FETCH.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; goes to ALUWB, which writes OldPC+4 to rd.
REQ-022 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; goes to FETCH.
REQ-023 LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; goes to ALUWB.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 Unreachable encodings 12-15 SHALL drive all outputs 0 and go to FETCH.
REQ-026 Cycle counts with mem_ready=1 throughout: R/I/U 4 cycles, branch 3, jal 4, load 5, store 4.

Reset
REQ-027 On reset=1 at a clock edge, state SHALL become FETCH.
REQ-028 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and illegal_instr SHALL be forced to 0 combinationally; all other outputs follow state.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction with no further architectural writes.

Structure
REQ-030 Opcode constants (RType, IType_logic, IType_load, SType, BType, JType, UType) SHALL come from the shared params file.
REQ-031 A state_t enum, ALUOp encodings and mux-select encodings SHALL be added to the shared types package.
REQ-032 control_fsm SHALL be a single module with no sub-modules; it drives Instruction_Decode's ALUOp and RegWrite.

Verification
REQ-033 add x3,x1,x2 (0x002081B3), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in ALUWB; ALUOp=10 in EXECUTER.
REQ-034 lw x3,0(x1) (0x0000A183), mem_ready low 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; RegWrite=1 only in MEMWB with ResultSrc=01.
REQ-035 beq opcode 1100011: zero=1 -> PCWrite=1 in BEQ; repeat with zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-036 Opcode 0x7F -> illegal_instr=1 for one cycle in DECODE, next state FETCH, no write enables asserted.
REQ-037 sw with reset asserted during MEMWRITE -> MemWrite=0 in the same cycle, state=0 after the edge, then normal fetch.
